// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB packet receive controller.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHunt,
    StPid,
    StBody,
    StEop,
    StReport
  } state_e;

  typedef enum logic [1:0] {
    KindHs   = 2'd0,
    KindTok  = 2'd1,
    KindData = 2'd2
  } kind_e;

  typedef enum logic [2:0] {
    FailNone     = 3'd0,
    FailTimeout  = 3'd1,
    FailPidCmp   = 3'd2,
    FailPidKind  = 3'd3,
    FailCrc      = 3'd4,
    FailEarlySe0 = 3'd5,
    FailEop      = 3'd6
  } fail_e;

  localparam logic [4:0]  Crc5Poly   = 5'h05;
  localparam logic [4:0]  Crc5Init   = 5'h1F;
  localparam logic [4:0]  Crc5Resid  = 5'h0C;
  localparam logic [15:0] Crc16Poly  = 16'h8005;
  localparam logic [15:0] Crc16Init  = 16'hFFFF;
  localparam logic [15:0] Crc16Resid = 16'h800D;

  // PID[1:0] identifies the packet class
  localparam logic [1:0] PidTypeHs   = 2'b10;
  localparam logic [1:0] PidTypeTok  = 2'b01;
  localparam logic [1:0] PidTypeData = 2'b11;

  function automatic logic [1:0] pid_type(kind_e k);
    case (k)
      KindTok:  return PidTypeTok;
      KindData: return PidTypeData;
      default:  return PidTypeHs;
    endcase
  endfunction

endpackage

// File: rtl/usb_crc_check.sv
// Serial CRC5/CRC16 checker; residual_ok reflects the state after the current bit.
module usb_crc_check import usb_rx_pkg::*; (
  input  logic clk,
  input  logic rst_L,
  input  logic init,
  input  logic en,
  input  logic sel16,
  input  logic bit_in,
  output logic residual_ok
);

  logic [15:0] crc_q, crc_d, crc_next;
  logic        fb;

  // Next CRC value with the incoming bit folded in (LSB-first data).
  always_comb begin
    fb       = 1'b0;
    crc_next = crc_q;
    if (sel16) begin
      fb       = bit_in ^ crc_q[15];
      crc_next = {crc_q[14:0], 1'b0} ^ (fb ? Crc16Poly : 16'h0000);
    end else begin
      fb       = bit_in ^ crc_q[4];
      crc_next = {11'h000, crc_q[3:0], 1'b0} ^ {11'h000, (fb ? Crc5Poly : 5'h00)};
    end
  end

  // Register update: init wins over shifting.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = sel16 ? Crc16Init : {11'h000, Crc5Init};
    end else if (en) begin
      crc_d = crc_next;
    end
  end

  // CRC state register.
  always_ff @(posedge clk) begin
    if (!rst_L) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign residual_ok = sel16 ? (crc_next == Crc16Resid) : (crc_next[4:0] == Crc5Resid);

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// USB packet receive controller: SYNC hunt, PID check, body with CRC, EOP, one report.
module usb_rx_pkt_ctrl import usb_rx_pkg::*; #(
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned EOP_CYCLES     = 2,
  localparam int unsigned LW = $clog2(MAX_DATA_BYTES + 1),
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1),
  localparam int unsigned BW = $clog2(8 * MAX_DATA_BYTES + 17),
  localparam int unsigned EW = $clog2(EOP_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_L,
  input  logic          start,
  input  logic [1:0]    kind,
  input  logic [LW-1:0] data_len,
  input  logic          pause,
  input  logic          sync_valid,
  input  logic          rx_bit,
  input  logic          se0,
  output logic          busy,
  output logic [3:0]    pid,
  output logic [10:0]   token,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  output logic          done,
  output logic          success,
  output logic          fail,
  output logic [2:0]    fail_code
);

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  fail_e         fail_code_q, fail_code_d;
  logic [BW-1:0] n_bits_q, n_bits_d, bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [EW-1:0] eop_cnt_q, eop_cnt_d;
  logic [7:0]    sr_q, sr_d, byte_out_q, byte_out_d;
  logic [3:0]    pid_q, pid_d;
  logic [10:0]   token_q, token_d;
  logic          byte_valid_q, byte_valid_d;
  logic          crc_init, crc_en, crc_ok;
  logic [LW-1:0] len_clamp;
  logic [7:0]    sr_full;

  assign len_clamp = (data_len > LW'(MAX_DATA_BYTES)) ? LW'(MAX_DATA_BYTES) : data_len;
  assign sr_full   = {rx_bit, sr_q[7:1]};

  usb_crc_check u_crc (
    .clk         (clk),
    .rst_L       (rst_L),
    .init        (crc_init),
    .en          (crc_en),
    .sel16       (kind_q == KindData),
    .bit_in      (rx_bit),
    .residual_ok (crc_ok)
  );

  // Next-state logic; pause freezes every working state, IDLE and REPORT ignore it.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    n_bits_d     = n_bits_q;
    to_cnt_d     = to_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    eop_cnt_d    = eop_cnt_q;
    sr_d         = sr_q;
    pid_d        = pid_q;
    token_d      = token_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    fail_code_d  = fail_code_q;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHunt;
          if (kind == 2'd1)      kind_d = KindTok;
          else if (kind == 2'd2) kind_d = KindData;
          else                   kind_d = KindHs;
          n_bits_d    = (kind == 2'd2) ? ((BW'(len_clamp) << 3) + BW'(16)) : BW'(16);
          to_cnt_d    = '0;
          bit_cnt_d   = '0;
          eop_cnt_d   = '0;
          sr_d        = '0;
          token_d     = '0;
          fail_code_d = FailNone;
        end
      end
      StHunt: begin
        if (!pause) begin
          if (sync_valid) begin
            state_d   = StPid;
            bit_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
              fail_code_d = FailTimeout;
              state_d     = StReport;
            end
          end
        end
      end
      StPid: begin
        if (!pause) begin
          sr_d      = sr_full;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(7)) begin
            pid_d     = sr_full[3:0];
            bit_cnt_d = '0;
            if (sr_full[7:4] != ~sr_full[3:0]) begin
              fail_code_d = FailPidCmp;
              state_d     = StReport;
            end else if (sr_full[1:0] != pid_type(kind_q)) begin
              fail_code_d = FailPidKind;
              state_d     = StReport;
            end else if (kind_q == KindHs) begin
              state_d   = StEop;
              eop_cnt_d = '0;
            end else begin
              state_d  = StBody;
              crc_init = 1'b1;
            end
          end
        end
      end
      StBody: begin
        if (!pause) begin
          if (se0) begin
            fail_code_d = FailEarlySe0;
            state_d     = StReport;
          end else begin
            crc_en    = 1'b1;
            sr_d      = sr_full;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (kind_q == KindTok && bit_cnt_q < BW'(11)) token_d = {rx_bit, token_q[10:1]};
            // Strobe only completed payload bytes, never the trailing CRC.
            if (kind_q == KindData && bit_cnt_q[2:0] == 3'd7 &&
                bit_cnt_q < n_bits_q - BW'(16)) begin
              byte_out_d   = sr_full;
              byte_valid_d = 1'b1;
            end
            if (bit_cnt_q == n_bits_q - BW'(1)) begin
              if (!crc_ok) fail_code_d = FailCrc;
              state_d   = StEop;
              eop_cnt_d = '0;
            end
          end
        end
      end
      StEop: begin
        if (!pause) begin
          if (se0) begin
            eop_cnt_d = eop_cnt_q + EW'(1);
            if (eop_cnt_q == EW'(EOP_CYCLES - 1)) state_d = StReport;
          end else begin
            if (fail_code_q == FailNone) fail_code_d = FailEop;
            state_d = StReport;
          end
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q      <= StIdle;
      kind_q       <= KindHs;
      n_bits_q     <= '0;
      to_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      eop_cnt_q    <= '0;
      sr_q         <= '0;
      pid_q        <= '0;
      token_q      <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      fail_code_q  <= FailNone;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      n_bits_q     <= n_bits_d;
      to_cnt_q     <= to_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      eop_cnt_q    <= eop_cnt_d;
      sr_q         <= sr_d;
      pid_q        <= pid_d;
      token_q      <= token_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      fail_code_q  <= fail_code_d;
    end
  end

  // busy already reads low in the REPORT cycle, alongside done.
  assign busy       = (state_q != StIdle) && (state_q != StReport);
  assign done       = (state_q == StReport);
  assign success    = done && (fail_code_q == FailNone);
  assign fail       = done && (fail_code_q != FailNone);
  assign fail_code  = fail_code_q;
  assign pid        = pid_q;
  assign token      = token_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Scoreboard bench: driver pushes expected bytes/reports, negedge monitor pops and compares.
module tb_usb_rx_pkt_ctrl;

  localparam int MAXB = 64;
  localparam int TO   = 255;
  localparam int EOPC = 2;
  localparam int LW   = 7;

  logic          clk = 1'b0;
  logic          rst_L, start, pause, sync_valid, rx_bit, se0;
  logic [1:0]    kind;
  logic [LW-1:0] data_len;
  logic          busy, byte_valid, done, success, fail;
  logic [3:0]    pid;
  logic [10:0]   token;
  logic [7:0]    byte_out;
  logic [2:0]    fail_code;

  usb_rx_pkt_ctrl #(
    .MAX_DATA_BYTES (MAXB),
    .TIMEOUT_CYCLES (TO),
    .EOP_CYCLES     (EOPC)
  ) dut (
    .clk        (clk),
    .rst_L      (rst_L),
    .start      (start),
    .kind       (kind),
    .data_len   (data_len),
    .pause      (pause),
    .sync_valid (sync_valid),
    .rx_bit     (rx_bit),
    .se0        (se0),
    .busy       (busy),
    .pid        (pid),
    .token      (token),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .done       (done),
    .success    (success),
    .fail       (fail),
    .fail_code  (fail_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          code;
    bit          chk_pid;
    logic [3:0]  pid;
    bit          chk_tok;
    logic [10:0] tok;
  } rep_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  rep_t        exp_reps[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  pl_q[$];
  logic [10:0] tok_field;
  rep_t        pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every DUT strobe against the scoreboard queues.
  always @(negedge clk) begin
    rep_t r;
    if (byte_valid === 1'b1) begin
      if (exp_bytes.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", byte_out, cyc);
      end else begin
        chk("byte_out", 32'(byte_out), 32'(exp_bytes.pop_front()));
      end
    end
    if (done === 1'b1) begin
      if (exp_reps.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        r = exp_reps.pop_front();
        chk("done_cycle", 32'(cyc), 32'(r.due));
        chk("fail_code", 32'(fail_code), 32'(r.code));
        chk("success", 32'(success), 32'(r.code == 0));
        chk("fail", 32'(fail), 32'(r.code != 0));
        chk("busy_at_done", 32'(busy), 32'(0));
        chk("bytes_pending", 32'(exp_bytes.size()), 32'(0));
        if (r.chk_pid) chk("pid", 32'(pid), 32'(r.pid));
        if (r.chk_tok) chk("token", 32'(token), 32'(r.tok));
      end
    end
    if (exp_reps.size() > 0 && cyc > exp_reps[0].due) begin
      checks++; failures++;
      $display("FAIL missing_done: got none expected done at cycle %0d", exp_reps[0].due);
      void'(exp_reps.pop_front());
    end
  end

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  task automatic junk_start();
    start    = ($urandom % 6 == 0);
    kind     = 2'($urandom);
    data_len = LW'($urandom);
  endtask

  // One meaningful unpaused cycle, optionally preceded by ignored paused cycles.
  task automatic cyc_drive(input logic s_sync, input logic s_bit, input logic s_se0, input bit last);
    if ($urandom % 5 == 0) begin
      repeat (1 + $urandom % 2) begin
        pause = 1'b1; sync_valid = rb(); rx_bit = rb(); se0 = rb(); junk_start();
        @(posedge clk); #1;
      end
    end
    pause = 1'b0; sync_valid = s_sync; rx_bit = s_bit; se0 = s_se0; junk_start();
    if (last) begin
      pend.due = cyc + 1;
      exp_reps.push_back(pend);
    end
    @(posedge clk); #1;
  endtask

  task automatic report_cycle();
    pause = 1'b0; sync_valid = rb(); rx_bit = rb(); se0 = rb(); junk_start();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1 + $urandom % 2) begin
      pause = rb(); sync_valid = rb(); rx_bit = rb(); se0 = rb();
      @(posedge clk); #1;
    end
    pause = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_success"}, 32'(success), 32'(0));
    chk({tag, "_fail"}, 32'(fail), 32'(0));
    chk({tag, "_pid"}, 32'(pid), 32'(0));
    chk({tag, "_token"}, 32'(token), 32'(0));
    chk({tag, "_byte_out"}, 32'(byte_out), 32'(0));
    chk({tag, "_byte_valid"}, 32'(byte_valid), 32'(0));
    chk({tag, "_fail_code"}, 32'(fail_code), 32'(0));
  endtask

  // Builds the packet from the protocol rules, predicts the outcome and drives it.
  task automatic run_pkt(input int kin, input logic [7:0] pidb, input int len_in,
                         input int hunt_idle, input int flip_pos, input int se0_at,
                         input int eop_n, input int abort_at);
    int          k, len_c;
    logic [1:0]  ptype;
    bit          bits[$];
    logic [7:0]  by;
    logic [4:0]  c5;
    logic [15:0] c16;
    bit          fb, crc_bad;
    k     = (kin == 1) ? 1 : ((kin == 2) ? 2 : 0);
    len_c = (len_in > MAXB) ? MAXB : len_in;
    ptype = (k == 1) ? 2'b01 : ((k == 2) ? 2'b11 : 2'b10);
    bits.delete();
    if (k == 1) begin
      c5 = 5'h1F;
      for (int i = 0; i < 11; i++) begin
        bits.push_back(tok_field[i]);
        fb = tok_field[i] ^ c5[4];
        c5 = {c5[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
      c5 = ~c5;
      for (int i = 4; i >= 0; i--) bits.push_back(c5[i]);
    end else if (k == 2) begin
      c16 = 16'hFFFF;
      for (int j = 0; j < len_c; j++) begin
        by = (j < pl_q.size()) ? pl_q[j] : 8'($urandom);
        for (int b = 0; b < 8; b++) begin
          bits.push_back(by[b]);
          fb  = by[b] ^ c16[15];
          c16 = {c16[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
      end
      c16 = ~c16;
      for (int i = 15; i >= 0; i--) bits.push_back(c16[i]);
    end
    crc_bad = (k != 0) && (flip_pos >= 0) && (flip_pos < bits.size());
    if (crc_bad) bits[flip_pos] = !bits[flip_pos];

    pend.code = 0; pend.chk_pid = 0; pend.pid = '0; pend.chk_tok = 0; pend.tok = '0;

    start = 1'b1; kind = 2'(kin); data_len = LW'(len_in);
    pause = rb(); sync_valid = rb(); rx_bit = rb(); se0 = rb();
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));

    if (hunt_idle >= TO) begin
      pend.code = 1;
      for (int i = 0; i < TO; i++) cyc_drive(1'b0, rb(), rb(), i == TO - 1);
      report_cycle();
      return;
    end
    for (int i = 0; i < hunt_idle; i++) cyc_drive(1'b0, rb(), rb(), 1'b0);
    cyc_drive(1'b1, rb(), rb(), 1'b0);

    pend.chk_pid = 1; pend.pid = pidb[3:0];
    if (pidb[7:4] != ~pidb[3:0]) pend.code = 2;
    else if (pidb[1:0] != ptype) pend.code = 3;
    for (int i = 0; i < 8; i++) cyc_drive(1'b0, pidb[i], 1'b0, (i == 7) && (pend.code != 0));
    if (pend.code != 0) begin
      report_cycle();
      return;
    end

    for (int i = 0; i < bits.size(); i++) begin
      if (i == abort_at) begin
        rst_L = 1'b0; pause = 1'b0; sync_valid = rb(); rx_bit = rb(); se0 = rb();
        @(posedge clk); #1;
        check_reset_outputs("abort");
        rst_L = 1'b1;
        repeat (4) begin
          sync_valid = rb(); rx_bit = rb(); se0 = rb();
          @(posedge clk); #1;
        end
        return;
      end
      if (i == se0_at) begin
        pend.code = 5;
        cyc_drive(1'b0, rb(), 1'b1, 1'b1);
        report_cycle();
        return;
      end
      if (k == 2 && i % 8 == 7 && i < 8 * len_c) begin
        for (int b = 0; b < 8; b++) by[b] = bits[i - 7 + b];
        exp_bytes.push_back(by);
      end
      cyc_drive(1'b0, bits[i], 1'b0, 1'b0);
    end
    if (k == 1) begin
      pend.chk_tok = 1;
      for (int i = 0; i < 11; i++) pend.tok[i] = bits[i];
    end

    if (eop_n >= EOPC) begin
      pend.code = crc_bad ? 4 : 0;
      for (int j = 0; j < EOPC; j++) cyc_drive(1'b0, rb(), 1'b1, j == EOPC - 1);
    end else begin
      pend.code = crc_bad ? 4 : 6;
      for (int j = 0; j < eop_n; j++) cyc_drive(1'b0, rb(), 1'b1, 1'b0);
      cyc_drive(1'b0, rb(), 1'b0, 1'b1);
    end
    report_cycle();
  endtask

  function automatic logic [7:0] pick_pid(input int k);
    logic [7:0] hs[3]  = '{8'hD2, 8'h5A, 8'h1E};
    logic [7:0] tk[3]  = '{8'hE1, 8'h69, 8'h2D};
    logic [7:0] dt[2]  = '{8'hC3, 8'h4B};
    if (k == 1) return tk[$urandom % 3];
    if (k == 2) return dt[$urandom % 2];
    return hs[$urandom % 3];
  endfunction

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got no finish expected end of run (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int kin, k, len, nb;
    rst_L = 1'b0; start = 1'b0; pause = 1'b0; sync_valid = 1'b0; rx_bit = 1'b0; se0 = 1'b0;
    kind = '0; data_len = '0; tok_field = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_L = 1'b1;
    @(posedge clk); #1;

    // ACK handshake
    run_pkt(0, 8'hD2, 0, 0, -1, -1, EOPC, -1);
    // DATA0 with two known bytes
    pl_q = '{8'h00, 8'h01};
    run_pkt(2, 8'hC3, 2, 1, -1, -1, EOPC, -1);
    pl_q.delete();
    // OUT token addr 3A endp 1, then with one CRC bit flipped
    tok_field = 11'h0BA;
    run_pkt(1, 8'hE1, 0, 0, -1, -1, EOPC, -1);
    run_pkt(1, 8'hE1, 0, 2, 13, -1, EOPC, -1);
    // Timeout, and sync on the final hunt cycle
    run_pkt(0, 8'hD2, 0, TO, -1, -1, EOPC, -1);
    run_pkt(0, 8'hD2, 0, TO - 1, -1, -1, EOPC, -1);
    // PID complement and kind errors
    run_pkt(0, 8'hD3, 0, 0, -1, -1, EOPC, -1);
    run_pkt(2, 8'hE1, 1, 0, -1, -1, EOPC, -1);
    // Early SE0 mid-body, short EOP, CRC error with short EOP
    run_pkt(2, 8'h4B, 3, 0, -1, 10, EOPC, -1);
    run_pkt(0, 8'h5A, 0, 0, -1, -1, 1, -1);
    run_pkt(2, 8'hC3, 1, 0, 3, -1, 0, -1);
    // Reset mid-body
    run_pkt(2, 8'hC3, 4, 0, -1, -1, EOPC, 20);
    // Zero length, clamped length, kind 3 treated as handshake
    run_pkt(2, 8'h4B, 0, 0, -1, -1, EOPC, -1);
    run_pkt(2, 8'hC3, 100, 0, -1, -1, EOPC, -1);
    run_pkt(3, 8'h1E, 0, 0, -1, -1, EOPC, -1);

    for (int n = 0; n < 40; n++) begin
      kin = $urandom % 4;
      k   = (kin == 1) ? 1 : ((kin == 2) ? 2 : 0);
      len = $urandom % 7;
      nb  = (k == 1) ? 16 : 8 * len + 16;
      tok_field = 11'($urandom);
      run_pkt(kin,
              ($urandom % 8 == 0) ? 8'($urandom) : pick_pid(($urandom % 10 == 0) ? 2 - k : k),
              len,
              $urandom % 5,
              ($urandom % 10 == 0) ? int'($urandom % nb) : -1,
              ($urandom % 10 == 0) ? int'($urandom % nb) : -1,
              ($urandom % 10 == 0) ? int'($urandom % EOPC) : EOPC,
              -1);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("reports_left", 32'(exp_reps.size()), 32'(0));
    chk("bytes_left", 32'(exp_bytes.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
